xp2s: RTL and testbench

XP2S -- requirements
Module: xp2s

---
 rtl/xp2s.sv | 119 +++++++++++
 tb/tb_xp2s.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/xp2s.sv
`default_nettype none
// xp2s: buffers parallel words in a small FIFO and serialises them one
// BWID-bit lane per i_ce strobe, lane 0 first, with gapless word chaining.
module xp2s #(
  parameter int BWID  = 8,
  parameter int Npar  = 4,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BWID*Npar-1:0] iv_data,
  input  logic                 i_dv,
  input  logic                 i_trig,
  input  logic                 i_ce,
  output logic                 o_rdy,
  output logic [BWID-1:0]      ov_data,
  output logic                 o_nd,
  output logic                 o_trig,
  output logic                 o_ovf
);
  localparam int WW = BWID * Npar;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(DEPTH + 1);
  localparam int CW = (Npar > 1) ? $clog2(Npar) : 1;
  localparam logic [NW-1:0] FULL = NW'(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(Npar - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
  state_t state, state_nxt;

  logic [WW:0]     mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [NW-1:0]   count;
  logic [WW-1:0]   word;
  logic            trig;
  logic [CW-1:0]   cnt;
  logic [BWID-1:0] lanes [Npar];
  logic            push, pop, emit, nonempty;

  // Ready depends only on the registered count (and reset), never on i_dv.
  assign o_rdy    = (count < FULL) && !rst;
  assign push     = i_dv && o_rdy;
  assign nonempty = (count != '0);

  for (genvar k = 0; k < Npar; k++) begin : g_lane
    assign lanes[k] = word[BWID*k +: BWID];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {i_trig, iv_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (push && !pop)      count <= count + NW'(1);
      else if (pop && !push) count <= count - NW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    emit      = 1'b0;
    case (state)
      IDLE: begin
        if (nonempty) begin
          pop       = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (i_ce) begin
          emit = 1'b1;
          // Last lane: chain straight into the next word when one is waiting.
          if (cnt == LAST) begin
            if (nonempty) pop = 1'b1;
            else          state_nxt = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word    <= '0;
      trig    <= 1'b0;
      cnt     <= '0;
      ov_data <= '0;
      o_nd    <= 1'b0;
      o_trig  <= 1'b0;
      o_ovf   <= 1'b0;
    end else begin
      o_nd   <= emit;
      o_trig <= emit && trig && (cnt == '0);
      if (emit) ov_data <= lanes[cnt];
      if (pop) begin
        {trig, word} <= mem[rptr];
        cnt          <= '0;
      end else if (emit && (cnt != LAST)) begin
        cnt <= cnt + CW'(1);
      end
      if (i_dv && !o_rdy) o_ovf <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xp2s.sv
`default_nettype none
// Directed bench for xp2s: latency, chaining, pacing, overflow, reset.
module tb_xp2s;
  localparam int BWID  = 8;
  localparam int NPAR  = 4;
  localparam int DEPTH = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [BWID*NPAR-1:0] iv_data;
  logic                 i_dv, i_trig, i_ce;
  logic                 o_rdy, o_nd, o_trig, o_ovf;
  logic [BWID-1:0]      ov_data;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_d[$];
  logic       exp_t[$];
  logic [7:0] held;
  int         lane;
  logic       seen;

  xp2s #(.BWID(BWID), .Npar(NPAR), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .iv_data(iv_data), .i_dv(i_dv), .i_trig(i_trig),
    .i_ce(i_ce), .o_rdy(o_rdy), .ov_data(ov_data), .o_nd(o_nd),
    .o_trig(o_trig), .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a word before the next rising edge; returns on the following negedge.
  task automatic push_word(input logic [31:0] d, input logic t);
    iv_data = d;
    i_dv    = 1'b1;
    i_trig  = t;
    @(negedge clk);
  endtask

  // Wait (bounded) for the first sample, then expect exp_d/exp_t back to back.
  task automatic collect(input string tag);
    int waited = 0;
    while (!o_nd && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    if (!o_nd) begin
      check({tag, "_start"}, o_nd, 1);
    end else begin
      foreach (exp_d[i]) begin
        if (i > 0) @(negedge clk);
        check($sformatf("%s_nd%0d", tag, i), o_nd, 1);
        check($sformatf("%s_data%0d", tag, i), ov_data, exp_d[i]);
        check($sformatf("%s_trig%0d", tag, i), o_trig, exp_t[i]);
      end
    end
    exp_d.delete();
    exp_t.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    iv_data = '0; i_dv = 1'b0; i_trig = 1'b0; i_ce = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rdy",  o_rdy, 0);
    check("rst_nd",   o_nd, 0);
    check("rst_trig", o_trig, 0);
    check("rst_ovf",  o_ovf, 0);
    check("rst_data", ov_data, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rdy_after_rst", o_rdy, 1);

    // Single word: lane 0 appears after E+2, trig only on lane 0.
    i_ce = 1'b1;
    push_word(32'h44332211, 1'b1);
    i_dv = 1'b0; i_trig = 1'b0;
    check("lat_e1", o_nd, 0);
    @(negedge clk);
    check("lat_e2_pre", o_nd, 0);
    @(negedge clk);
    check("lat_e2", o_nd, 1);
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_t = '{1'b1, 1'b0, 1'b0, 1'b0};
    collect("single");
    @(negedge clk);
    check("single_end_nd", o_nd, 0);
    check("single_hold", ov_data, 8'h44);

    // Back to back: gapless, trig of second word only on its own lane 0.
    push_word(32'h04030201, 1'b0);
    check("b2b_rdy1", o_rdy, 1);
    push_word(32'h08070605, 1'b1);
    check("b2b_rdy2", o_rdy, 1);
    i_dv = 1'b0; i_trig = 1'b0;
    exp_d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    exp_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    collect("b2b");
    @(negedge clk);
    check("b2b_end_nd", o_nd, 0);

    // Pacing: i_ce alternating; data held on the gaps.
    i_ce = 1'b0;
    push_word(32'h0D0C0B0A, 1'b0);
    i_dv = 1'b0;
    @(negedge clk);
    held = 8'h08;
    lane = 0;
    for (int i = 0; i < 8; i++) begin
      i_ce = (i % 2 == 0);
      @(negedge clk);
      if (i % 2 == 0) begin
        held = 8'h0A + 8'(lane);
        lane++;
      end
      check($sformatf("pace_nd%0d", i), o_nd, (i % 2 == 0));
      check($sformatf("pace_data%0d", i), ov_data, held);
    end
    i_ce = 1'b0;

    // Overflow: first word sits in the shift register, two more fill the FIFO,
    // the fourth is dropped.
    push_word(32'h14131211, 1'b0);
    push_word(32'h24232221, 1'b0);
    check("ovf_rdy1", o_rdy, 1);
    push_word(32'h34333231, 1'b0);
    check("ovf_rdy_full", o_rdy, 0);
    check("ovf_not_yet", o_ovf, 0);
    push_word(32'h44434241, 1'b0);
    i_dv = 1'b0;
    check("ovf_set", o_ovf, 1);
    check("ovf_rdy_still", o_rdy, 0);
    @(negedge clk);
    check("ovf_sticky1", o_ovf, 1);
    i_ce = 1'b1;
    exp_d = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h21, 8'h22, 8'h23, 8'h24,
              8'h31, 8'h32, 8'h33, 8'h34};
    exp_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              1'b0, 1'b0, 1'b0, 1'b0};
    collect("ovf");
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen |= o_nd;
    end
    check("ovf_dropped", seen, 0);
    check("ovf_sticky2", o_ovf, 1);
    check("ovf_rdy_back", o_rdy, 1);

    // Reset mid-word with a second word still buffered.
    push_word(32'h54535251, 1'b0);
    push_word(32'h64636261, 1'b0);
    i_dv = 1'b0;
    exp_d = '{8'h51, 8'h52};
    exp_t = '{1'b0, 1'b0};
    collect("pre_rst");
    #1 rst = 1'b1;
    #1;
    check("mrst_nd",   o_nd, 0);
    check("mrst_data", ov_data, 0);
    check("mrst_trig", o_trig, 0);
    check("mrst_ovf",  o_ovf, 0);
    check("mrst_rdy",  o_rdy, 0);
    @(negedge clk);
    check("mrst_rdy_hold", o_rdy, 0);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_rdy_after", o_rdy, 1);
    seen = o_nd;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen |= o_nd;
    end
    check("mrst_no_nd", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
